// File: rtl/aap_isa_pkg.sv
// Shared AAP instruction-set definitions: encoder FSM states, parcel field
// positions and the short-form register limit. Also used by the decoder.
package aap_isa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHORT   = 2'd1,
        LONG_LO = 2'd2,
        LONG_HI = 2'd3
    } enc_state_t;

    localparam int unsigned PARCEL_BITS = 16;
    localparam int unsigned OPC_BITS    = 6;
    localparam int unsigned FLD_BITS    = 3;

    localparam int unsigned FORM_BIT = 15;
    localparam int unsigned OPC_MSB  = 14;
    localparam int unsigned OPC_LSB  = 9;
    localparam int unsigned DST_MSB  = 8;
    localparam int unsigned DST_LSB  = 6;
    localparam int unsigned SR1_MSB  = 5;
    localparam int unsigned SR1_LSB  = 3;
    localparam int unsigned SR2_MSB  = 2;
    localparam int unsigned SR2_LSB  = 0;

    // Largest register index encodable in a short (single-parcel) instruction.
    localparam int unsigned SHORT_LIMIT = 7;

endpackage

// File: rtl/aap_parcel_pack.sv
// Combinational parcel packer: builds a short/long-lo parcel from field low
// bits, or a long-hi parcel from field high bits when hi=1.
module aap_parcel_pack
    import aap_isa_pkg::*;
#(
    parameter int unsigned REG_W = 6
) (
    input  logic [OPC_BITS-1:0]    opcode,
    input  logic [REG_W-1:0]       dest,
    input  logic [REG_W-1:0]       src1,
    input  logic [REG_W-1:0]       src2,
    input  logic                   long_form,
    input  logic                   hi,
    output logic [PARCEL_BITS-1:0] parcel
);

    always_comb begin
        parcel = '0;
        if (hi) begin
            parcel[DST_MSB:DST_LSB] = dest[2*FLD_BITS-1:FLD_BITS];
            parcel[SR1_MSB:SR1_LSB] = src1[2*FLD_BITS-1:FLD_BITS];
            parcel[SR2_MSB:SR2_LSB] = src2[2*FLD_BITS-1:FLD_BITS];
        end else begin
            parcel[FORM_BIT]        = long_form;
            parcel[OPC_MSB:OPC_LSB] = opcode;
            parcel[DST_MSB:DST_LSB] = dest[FLD_BITS-1:0];
            parcel[SR1_MSB:SR1_LSB] = src1[FLD_BITS-1:0];
            parcel[SR2_MSB:SR2_LSB] = src2[FLD_BITS-1:0];
        end
    end

endmodule

// File: rtl/aap_instr_encoder.sv
// AAP instruction encoder: emits one 16-bit parcel (short) or two (long).
// Optional completion counters enabled by macro AAP_INSTR_ENCODER_STATS_EN.
module aap_instr_encoder
    import aap_isa_pkg::*;
#(
    parameter int unsigned PARCEL_W = 16,
    parameter int unsigned REG_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          in_opcode,
    input  logic [REG_W-1:0]    in_dest,
    input  logic [REG_W-1:0]    in_src1,
    input  logic [REG_W-1:0]    in_src2,
    input  logic                in_force_long,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PARCEL_W-1:0] out_parcel,
    output logic                out_last
`ifdef AAP_INSTR_ENCODER_STATS_EN
    ,
    output logic [15:0]         stat_short_cnt,
    output logic [15:0]         stat_long_cnt
`endif
);

    enc_state_t       state;
    logic [REG_W-1:0] dest_q;
    logic [REG_W-1:0] src1_q;
    logic [REG_W-1:0] src2_q;

    logic                   in_hs;
    logic                   out_hs;
    logic                   in_long;
    logic                   pack_hi;
    logic [REG_W-1:0]       pack_dest;
    logic [REG_W-1:0]       pack_src1;
    logic [REG_W-1:0]       pack_src2;
    logic [PARCEL_BITS-1:0] packed_parcel;

    always_comb begin
        in_ready = ~rst & ((state == IDLE) |
                           (((state == SHORT) | (state == LONG_HI)) & out_ready));
        in_hs    = in_valid & in_ready;
        out_hs   = out_valid & out_ready;
        in_long  = in_force_long |
                   (in_dest > REG_W'(SHORT_LIMIT)) |
                   (in_src1 > REG_W'(SHORT_LIMIT)) |
                   (in_src2 > REG_W'(SHORT_LIMIT));
    end

    // One packer serves both uses: live inputs for a first parcel, captured
    // fields for the hi parcel (only needed while sitting in LONG_LO).
    always_comb begin
        pack_hi   = (state == LONG_LO);
        pack_dest = pack_hi ? dest_q : in_dest;
        pack_src1 = pack_hi ? src1_q : in_src1;
        pack_src2 = pack_hi ? src2_q : in_src2;
    end

    aap_parcel_pack #(
        .REG_W (REG_W)
    ) u_pack (
        .opcode    (in_opcode),
        .dest      (pack_dest),
        .src1      (pack_src1),
        .src2      (pack_src2),
        .long_form (in_long),
        .hi        (pack_hi),
        .parcel    (packed_parcel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_parcel <= '0;
            out_last   <= 1'b0;
            dest_q     <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
        end else begin
            case (state)
                LONG_LO: begin
                    if (out_hs) begin
                        state      <= LONG_HI;
                        out_parcel <= PARCEL_W'(packed_parcel);
                        out_last   <= 1'b1;
                    end
                end
                default: begin
                    // in_hs outside IDLE already implies out_hs (in_ready needs out_ready)
                    if (in_hs) begin
                        state      <= in_long ? LONG_LO : SHORT;
                        out_valid  <= 1'b1;
                        out_parcel <= PARCEL_W'(packed_parcel);
                        out_last   <= ~in_long;
                        dest_q     <= in_dest;
                        src1_q     <= in_src1;
                        src2_q     <= in_src2;
                    end else if ((state != IDLE) && out_hs) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef AAP_INSTR_ENCODER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_short_cnt <= '0;
            stat_long_cnt  <= '0;
        end else if (out_hs && out_last) begin
            if (state == SHORT) begin
                if (stat_short_cnt != 16'hFFFF) stat_short_cnt <= stat_short_cnt + 16'd1;
            end else begin
                if (stat_long_cnt != 16'hFFFF) stat_long_cnt <= stat_long_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
